// File: rtl/csa_accumulator_pkg.sv
// Shared CNN datapath helpers: width relations, clog2, and the shift-then-clip
// used by post-adder stages.
package csa_accumulator_pkg;

    localparam int SAT_MAXW = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic [SAT_MAXW-1:0] val;
        logic                sat;
    } sat_res_t;

    // Ceiling log2; 0 for n <= 1 so a single-beat group needs no counter bits.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Width of carry_save_adder's {cout, sum} result.
    function automatic int csa_sum_width(input int w, input int e);
        return w + e + 1;
    endfunction

    function automatic sat_res_t sat_shift(input logic [SAT_MAXW-1:0] total,
                                           input int sh, input int ow);
        logic [SAT_MAXW-1:0] shifted;
        logic [SAT_MAXW-1:0] lim;
        sat_res_t            r;
        shifted = total >> sh;
        lim     = (SAT_MAXW'(1) << ow) - SAT_MAXW'(1);
        r.sat   = (shifted > lim);
        r.val   = r.sat ? lim : shifted;
        return r;
    endfunction

endpackage

// File: rtl/csa_acc_outreg.sv
// Valid/ready output register for csa_accumulator; loads one cycle after the final beat.
// Backpressure: stalls only the final beat while full and not draining (load+consume has no bubble).
module csa_acc_outreg #(
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_vld,
    input  logic [OW-1:0] load_dat,
    input  logic          load_sat,
    input  logic          last_beat,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    output logic          out_sat
);

    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic          out_sat_q, out_sat_d;

    assign in_ready = !(last_beat && out_valid_q && !out_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (load_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = load_dat;
            out_sat_d   = load_sat;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: rtl/csa_accumulator.sv
// Sums K consecutive CSA results, shifts right by SH, saturates to OW bits.
// Result registered one cycle after the final beat; only the final beat stalls on a full output.
module csa_accumulator
    import csa_accumulator_pkg::*;
#(
    parameter int W  = 4,
    parameter int E  = 3,
    parameter int K  = 4,
    parameter int SH = 0,
    parameter int OW = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [csa_sum_width(W, E)-1:0] in_sum,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OW-1:0]                 out_data,
    output logic                          out_sat
);

    localparam int SW   = csa_sum_width(W, E);
    localparam int CW   = clog2(K);
    localparam int CNTW = (CW == 0) ? 1 : CW;
    localparam int AW   = SW + CW;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(K - 1);

    logic [AW-1:0]   acc_q, acc_d, total;
    logic [CNTW-1:0] cnt_q, cnt_d;
    acc_state_t      state_q, state_d;
    logic            last_beat, accept, final_beat;
    sat_res_t        sat_res;
    logic [OW-1:0]   load_dat;

    assign last_beat  = (cnt_q == CNT_LAST);
    assign accept     = in_valid & in_ready;
    assign final_beat = accept & last_beat;
    // AW already covers K full-scale beats, so the sum cannot wrap.
    assign total      = acc_q + AW'(in_sum);
    assign sat_res    = sat_shift(SAT_MAXW'(total), SH, OW);
    assign load_dat   = OW'(sat_res.val);

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (accept) begin
            if (last_beat) begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                acc_d   = total;
                cnt_d   = cnt_q + CNTW'(1);
                state_d = ST_ACC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    csa_acc_outreg #(
        .OW(OW)
    ) u_outreg (
        .clk      (clk),
        .rst      (rst),
        .load_vld (final_beat),
        .load_dat (load_dat),
        .load_sat (sat_res.sat),
        .last_beat(last_beat),
        .out_ready(out_ready),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

endmodule
